// File: rtl/mul_share_arbiter_if.sv
// Bundle of the requester-facing signals of the shared multiplier.
// master: the requesting controllers; slave: the arbiter/multiplier.
interface mul_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       op;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic                   quiesce;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]     rsp_data;
    logic                   busy;
    logic                   idle;

    modport master (
        output req, op, a_in, b_in, quiesce,
        input  gnt, rsp_valid, rsp_data, busy, idle
    );

    modport slave (
        input  req, op, a_in, b_in, quiesce,
        output gnt, rsp_valid, rsp_data, busy, idle
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter in front of one shared pipelined multiplier.
// One grant per cycle; product returns tagged (one-hot) after LAT cycles.
//
// state   | meaning
// S_RUN   | granting requests round-robin from rr_ptr
// S_DRAIN | no grants, waiting for in-flight products to retire
// S_HALT  | no grants, pipeline empty, idle asserted
module mul_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int LAT   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mul_share_arbiter_if.slave      bus
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   cand;
    logic               gnt_any;
    logic [N_REQ-1:0]   gnt_c;
    logic               tail_any;
    logic [PW-1:0]      a_ext, b_ext, prod_c;
    logic               busy_q, idle_q;

    // Stage k holds the one-hot requester tag and product; stage LAT is the
    // response register itself.
    logic [N_REQ-1:0]   st_oh   [1:LAT];
    logic [PW-1:0]      st_prod [1:LAT];

    // Any valid op in stages that will still be in the pipe after this edge.
    always_comb begin
        tail_any = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            tail_any = tail_any | (|st_oh[k]);
        end
    end

    // Next-state, round-robin search and grant generation.
    always_comb begin
        state_next = state;
        gnt_any    = 1'b0;
        gnt_idx    = '0;
        cand       = '0;
        gnt_c      = '0;
        case (state)
            S_RUN: begin
                if (bus.quiesce) begin
                    state_next = S_DRAIN;
                end else begin
                    for (int k = 0; k < N_REQ; k++) begin
                        cand = PTR_W'((int'(rr_ptr) + k) % N_REQ);
                        if (!gnt_any && bus.req[cand]) begin
                            gnt_any = 1'b1;
                            gnt_idx = cand;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!bus.quiesce) begin
                    state_next = S_RUN;
                end else if (!tail_any) begin
                    state_next = S_HALT;
                end
            end
            S_HALT: begin
                if (!bus.quiesce) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_RUN;
        endcase
        // Requests are ignored while reset is held.
        if (!rst_n) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            gnt_c = N_REQ'(1) << gnt_idx;
        end
    end

    // Operand select and multiply; modulo 2^PW product is exact for signed
    // operands because sign-extended inputs cannot overflow 2*WIDTH bits.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        if (bus.op[gnt_idx]) begin
            a_ext = {{WIDTH{bus.a_in[int'(gnt_idx)*WIDTH + WIDTH-1]}},
                     bus.a_in[int'(gnt_idx)*WIDTH +: WIDTH]};
            b_ext = {{WIDTH{bus.b_in[int'(gnt_idx)*WIDTH + WIDTH-1]}},
                     bus.b_in[int'(gnt_idx)*WIDTH +: WIDTH]};
        end else begin
            a_ext = {{WIDTH{1'b0}}, bus.a_in[int'(gnt_idx)*WIDTH +: WIDTH]};
            b_ext = {{WIDTH{1'b0}}, bus.b_in[int'(gnt_idx)*WIDTH +: WIDTH]};
        end
        prod_c = a_ext * b_ext;
    end

    // State, round-robin pointer and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_RUN;
            rr_ptr <= '0;
            busy_q <= 1'b0;
            idle_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= gnt_any | tail_any;
            idle_q <= (state_next == S_HALT);
            if (gnt_any) begin
                rr_ptr <= (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Multiplier pipeline; data only moves with a valid tag so the
    // response data holds its last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= LAT; k++) begin
                st_oh[k]   <= '0;
                st_prod[k] <= '0;
            end
        end else begin
            st_oh[1] <= gnt_c;
            if (gnt_any) begin
                st_prod[1] <= prod_c;
            end
            for (int k = 2; k <= LAT; k++) begin
                st_oh[k] <= st_oh[k-1];
                if (|st_oh[k-1]) begin
                    st_prod[k] <= st_prod[k-1];
                end
            end
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.rsp_valid = st_oh[LAT];
    assign bus.rsp_data  = st_prod[LAT];
    assign bus.busy      = busy_q;
    assign bus.idle      = idle_q;

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin scheduler and shared pipelined multiplier. Up to N_REQ scheduled-datapath controllers submit multiply operations to this block, which grants one per cycle and returns each product tagged to its requester after a fixed latency. It replaces per-controller multipliers when several sequencers compete for one MUL resource. A quiesce/drain FSM lets the top level stop issue and wait for the pipeline to empty.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand width in bits
- LAT, 3, multiplier pipeline depth in cycles (1..6)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request; held high until granted
- op  in  N_REQ  per-requester mode: 0 = unsigned, 1 = signed (two's complement)
- a_in  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- b_in  in  N_REQ*WIDTH  operand B, same packing
- quiesce  in  1  level; stop granting and drain
- gnt  out  N_REQ  one-hot (or zero) grant, combinational from req and state
- rsp_valid  out  N_REQ  one-hot (or zero) result strobe, registered
- rsp_data  out  2*WIDTH  product, registered, valid when any rsp_valid bit is set
- busy  out  1  registered; any operation in flight
- idle  out  1  registered; FSM in S_HALT and pipeline empty

## Operation
- FSM states: S_RUN, S_DRAIN, S_HALT. Reset state S_RUN.
- S_RUN: gnt given to the first requester with req=1 searching upward from rr_ptr, wrapping at N_REQ. quiesce=1 -> S_DRAIN (no grant issued in the cycle quiesce is sampled high).
- S_DRAIN: gnt=0. When pipeline empty -> S_HALT. quiesce=0 in S_DRAIN -> S_RUN.
- S_HALT: gnt=0, idle=1. quiesce=0 -> S_RUN.
- rr_ptr: reset 0; on grant to index i, rr_ptr <= (i+1) mod N_REQ; unchanged without a grant.
- On grant edge: operands, op and requester index captured into stage 1; stages shift every cycle (no stall). Stage LAT drives rsp_valid (one-hot of index) and rsp_data.
- Unsigned: zero-extend both to 2*WIDTH, product modulo 2^(2*WIDTH). Signed: sign-extend, two's-complement product; exact, no overflow.
- Requester drops req the cycle after gnt or keeps it high to request again; each gnt cycle issues exactly one operation.
- busy = OR of stage valid bits (registered). idle = (state==S_HALT).

## Timing
- Reset: gnt=0 (req ignored while rst_n low), rsp_valid=0, rsp_data=0, busy=0, idle=0, all stage valids 0, rr_ptr=0, state S_RUN.
- Latency: grant in cycle t -> rsp_valid/rsp_data in cycle t+LAT, for exactly one cycle.
- Throughput: one issue per cycle; back-to-back grants give back-to-back responses in grant order.
- req, op, a_in, b_in sampled only at the edge ending a gnt cycle.
- Simultaneous: quiesce rising in the same cycle as req -> no grant; request remains pending.
- S_DRAIN -> S_HALT transition on the edge where the last stage retires; idle high the following cycle.
- Reset mid-operation: all in-flight operations discarded, no rsp_valid produced for them.
- req=0 everywhere: gnt=0, rr_ptr holds, pipeline bubbles propagate with valid=0; rsp_data holds last value.

## Test plan
- Single request: N_REQ=4, LAT=3, req=4'b0100, op=0, a=16'h00FF, b=16'h0101 granted cycle t -> gnt=4'b0100 in t, rsp_valid=4'b0100, rsp_data=32'h0000FFFF in t+3.
- Round robin: req=4'b1111 held 8 cycles from reset -> gnt sequence 0,1,2,3,0,1,2,3; responses in same order, one per cycle, no gaps.
- Signed: op=1, a=16'hFFFE (-2), b=16'h0003 -> rsp_data=32'hFFFFFFFA; same operands op=0 -> 32'h0002FFFA.
- Drain: issue 3 back-to-back ops, raise quiesce next cycle with req=4'b0011 held -> no further gnt, 3 responses delivered, busy falls, idle=1 one cycle after last retire; drop quiesce -> grant resumes from rr_ptr.
- Reset mid-flight: issue 2 ops, assert rst_n=0 one cycle later for 2 cycles -> rsp_valid stays 0, busy=0, first grant after release goes to requester 0.
- Skipping: rr_ptr=1, req=4'b1001 -> gnt=4'b1000, then rr_ptr wraps to 0, next gnt=4'b0001.
